// File: rtl/unsigned_approx_mult_pipe.sv
// unsigned_approx_mult_pipe
// Three-stage unsigned WIDTH x WIDTH multiplier. The low L multiplier rows can be
// truncated: their partial-product bits below column WIDTH are dropped and the bits
// at or above column WIDTH are kept, so the approximate product never exceeds the
// exact one. in_mode selects exact (1) or approximate (0) per transaction.
//
// Handshake: a beat transfers on a rising edge where valid && ready, on both the
// input (in_valid/in_ready) and the output (out_valid/out_ready). The only
// back-pressure source is the output stall (out_valid && !out_ready), which freezes
// every stage register and valid bit and drops in_ready. Otherwise all stages
// advance together, so in_ready depends only on out_valid/out_ready.
module unsigned_approx_mult_pipe #(
    parameter int WIDTH = 8,
    parameter int L     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [WIDTH-1:0]     in_y,
    input  logic                 in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_z,
    output logic                 out_mode,
    output logic [15:0]          done_cnt
);

    localparam int PW = 2 * WIDTH;
    // Selects the multiplier bits that form the approximated low rows.
    localparam logic [WIDTH-1:0] LO_MASK = WIDTH'((64'd1 << L) - 64'd1);

    if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
        $error("unsigned_approx_mult_pipe: WIDTH must be in 4..32");
    end
    if (L < 0 || L > WIDTH - 1) begin : g_bad_l
        $error("unsigned_approx_mult_pipe: L must be in 0..WIDTH-1");
    end

    // Stage 1: registered operands and mode
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_x_q;
    logic [WIDTH-1:0] s1_y_q;
    logic             s1_mode_q;

    // Stage 2: high-row product, low-row compensation, exact low-row product
    logic             s2_valid_q;
    logic             s2_mode_q;
    logic [PW-1:0]    s2_hi_q;
    logic [PW-1:0]    s2_comp_q;
    logic [PW-1:0]    s2_lo_q;
    logic [PW-1:0]    hi_d;
    logic [PW-1:0]    comp_d;
    logic [PW-1:0]    lo_d;

    // Stage 3: final result
    logic             s3_valid_q;
    logic             s3_mode_q;
    logic [PW-1:0]    s3_z_q;
    logic [PW-1:0]    z_d;

    logic [15:0]      done_cnt_q;
    logic             stall;
    logic             advance;
    logic             deliver;

    assign stall     = s3_valid_q && !out_ready;
    assign advance   = !stall;
    assign deliver   = s3_valid_q && out_ready;

    assign in_ready  = advance;
    assign out_valid = s3_valid_q;
    assign out_z     = s3_z_q;
    assign out_mode  = s3_mode_q;
    assign done_cnt  = done_cnt_q;

    // Stage 1 capture: operands enter whenever the pipe advances
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_mode_q  <= 1'b0;
        end else if (advance) begin
            s1_valid_q <= in_valid;
            s1_x_q     <= in_x;
            s1_y_q     <= in_y;
            s1_mode_q  <= in_mode;
        end
    end

    // Stage 2 terms: y*x_hi<<L, kept upper bits of the low rows, and exact y*x_lo
    always_comb begin
        hi_d   = PW'(s1_y_q) * PW'(s1_x_q & ~LO_MASK);
        lo_d   = PW'(s1_y_q) * PW'(s1_x_q & LO_MASK);
        comp_d = '0;
        for (int i = 0; i < L; i++) begin
            if (s1_x_q[i]) begin
                comp_d = comp_d + ((PW'(s1_y_q) >> (WIDTH - i)) << WIDTH);
            end
        end
    end

    // Stage 2 register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_mode_q  <= 1'b0;
            s2_hi_q    <= '0;
            s2_comp_q  <= '0;
            s2_lo_q    <= '0;
        end else if (advance) begin
            s2_valid_q <= s1_valid_q;
            s2_mode_q  <= s1_mode_q;
            s2_hi_q    <= hi_d;
            s2_comp_q  <= comp_d;
            s2_lo_q    <= lo_d;
        end
    end

    // Stage 3 sum: exact adds the true low rows, approximate adds the compensation
    always_comb begin
        z_d = s2_mode_q ? (s2_hi_q + s2_lo_q) : (s2_hi_q + s2_comp_q);
    end

    // Stage 3 register: holds the result stable while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_valid_q <= 1'b0;
            s3_mode_q  <= 1'b0;
            s3_z_q     <= '0;
        end else if (advance) begin
            s3_valid_q <= s2_valid_q;
            s3_mode_q  <= s2_mode_q;
            s3_z_q     <= z_d;
        end
    end

    // Delivery counter: free-running, wraps at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_cnt_q <= '0;
        end else if (deliver) begin
            done_cnt_q <= done_cnt_q + 16'd1;
        end
    end

endmodule
